// File: rtl/v6502_pkg.sv
// v6502 front-end shared definitions: bus widths and the fetch
// sequencer state encoding used by fetch_sequencer.
package v6502_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int IB_LEN_W = 2;

    // Number of bytes the prime decoder can look at in one cycle.
    localparam int IB_WINDOW = 3;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_PF_WAIT = 2'd1,
        FS_DT_WAIT = 2'd2,
        FS_PF_DROP = 2'd3
    } fs_state_t;

    // Bytes presented to the decoder: min(count, 3).
    function automatic logic [IB_LEN_W-1:0] ib_window(
        input logic [31:0] count
    );
        if (count >= 32'(IB_WINDOW)) begin
            return IB_LEN_W'(IB_WINDOW);
        end
        return count[IB_LEN_W-1:0];
    endfunction

endpackage

// File: rtl/pf_queue_store.sv
// Prefetch queue byte storage: DEPTH x DATA_W, one write port and three
// combinational read taps at rd_ptr, rd_ptr+1, rd_ptr+2 (mod DEPTH).
// Ports: clk, rst_n, wr_en, wr_ptr, wr_data, rd_ptr, rd_byte0..2.
module pf_queue_store
    import v6502_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_byte0,
    output logic [DATA_W-1:0] rd_byte1,
    output logic [DATA_W-1:0] rd_byte2
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] tap1;
    logic [PTR_W-1:0] tap2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    // Taps wrap naturally because the pointer is exactly log2(DEPTH) bits.
    always_comb begin
        tap1 = rd_ptr + PTR_W'(1);
        tap2 = rd_ptr + PTR_W'(2);
    end

    assign rd_byte0 = mem_q[rd_ptr];
    assign rd_byte1 = mem_q[tap1];
    assign rd_byte2 = mem_q[tap2];

endmodule

// File: rtl/fetch_sequencer.sv
// v6502 front-end: shares one memory port between prefetch and data
// accesses (data first), keeps a circular byte queue for the decoder.
// Ports: mem_* memory port, dat_* execute access, ib_* decoder window,
// redirect/redirect_pc branch flush.
module fetch_sequencer
    import v6502_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                QDEPTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                dat_req,
    input  logic                dat_we,
    input  logic [ADDR_W-1:0]   dat_addr,
    input  logic [DATA_W-1:0]   dat_wdata,
    output logic                dat_done,
    output logic [DATA_W-1:0]   dat_rdata,
    output logic [IB_LEN_W-1:0] ib_avail,
    output logic [DATA_W-1:0]   ib_byte0,
    output logic [DATA_W-1:0]   ib_byte1,
    output logic [DATA_W-1:0]   ib_byte2,
    output logic [ADDR_W-1:0]   ib_pc,
    input  logic                ib_consume,
    input  logic [IB_LEN_W-1:0] ib_len,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    fs_state_t         state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              dat_done_q,  dat_done_d;
    logic [DATA_W-1:0] dat_rdata_q, dat_rdata_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] fetch_pc_q,  fetch_pc_d;
    logic [ADDR_W-1:0] ib_pc_q,     ib_pc_d;

    logic             push;
    logic             pop_ok;
    logic             has_room;
    logic [CNT_W-1:0] pop_cnt;

    // ------------------------------------------------------------------
    // Memory port arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dat_done_d  = 1'b0;
        dat_rdata_d = dat_rdata_q;
        push        = 1'b0;
        has_room    = count_q < CNT_W'(QDEPTH);

        unique case (state_q)
            FS_IDLE: begin
                // While dat_done is high the requester still holds
                // dat_req for the finished access; do not restart it.
                if (!dat_done_q) begin
                    if (dat_req) begin
                        state_d     = FS_DT_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dat_we;
                        mem_addr_d  = dat_addr;
                        mem_wdata_d = dat_wdata;
                    end else if (has_room && !redirect) begin
                        state_d    = FS_PF_WAIT;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = fetch_pc_q;
                    end
                end
            end
            FS_PF_WAIT: begin
                if (mem_ack) begin
                    state_d   = FS_IDLE;
                    mem_req_d = 1'b0;
                    push      = !redirect;
                end else if (redirect) begin
                    // Bus cycle cannot be cancelled; let it finish
                    // and discard the byte.
                    state_d = FS_PF_DROP;
                end
            end
            FS_PF_DROP: begin
                if (mem_ack) begin
                    state_d   = FS_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            FS_DT_WAIT: begin
                if (mem_ack) begin
                    state_d     = FS_IDLE;
                    mem_req_d   = 1'b0;
                    dat_done_d  = 1'b1;
                    dat_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d   = FS_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Queue pointers, occupancy and program counters
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        ib_pc_d    = ib_pc_q;

        // Legality uses the occupancy before this cycle's push.
        pop_ok  = ib_consume
               && (ib_len != '0)
               && (CNT_W'(ib_len) <= count_q);
        pop_cnt = pop_ok ? CNT_W'(ib_len) : '0;

        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            fetch_pc_d = redirect_pc;
            ib_pc_d    = redirect_pc;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(ib_len);
                ib_pc_d  = ib_pc_q + ADDR_W'(ib_len);
            end
            count_d = count_q + CNT_W'(push) - pop_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dat_done_q  <= 1'b0;
            dat_rdata_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fetch_pc_q  <= RESET_PC;
            ib_pc_q     <= RESET_PC;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dat_done_q  <= dat_done_d;
            dat_rdata_q <= dat_rdata_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fetch_pc_q  <= fetch_pc_d;
            ib_pc_q     <= ib_pc_d;
        end
    end

    pf_queue_store #(
        .DEPTH (QDEPTH),
        .PTR_W (PTR_W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_ptr   (wr_ptr_q),
        .wr_data  (mem_rdata),
        .rd_ptr   (rd_ptr_q),
        .rd_byte0 (ib_byte0),
        .rd_byte1 (ib_byte1),
        .rd_byte2 (ib_byte2)
    );

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dat_done  = dat_done_q;
    assign dat_rdata = dat_rdata_q;
    assign ib_pc     = ib_pc_q;
    assign ib_avail  = ib_window(32'(count_q));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic,
// checked against a byte-stream model of the prefetch queue.
module tb_fetch_sequencer;
    import v6502_pkg::*;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          QD     = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        dat_req, dat_we, dat_done;
    logic [15:0] dat_addr;
    logic [7:0]  dat_wdata, dat_rdata;
    logic [1:0]  ib_avail, ib_len;
    logic [7:0]  ib_byte0, ib_byte1, ib_byte2;
    logic [15:0] ib_pc, redirect_pc;
    logic        ib_consume, redirect;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr),
        .dat_wdata(dat_wdata), .dat_done(dat_done), .dat_rdata(dat_rdata),
        .ib_avail(ib_avail), .ib_byte0(ib_byte0), .ib_byte1(ib_byte1),
        .ib_byte2(ib_byte2), .ib_pc(ib_pc), .ib_consume(ib_consume),
        .ib_len(ib_len), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory image seen by prefetch.
    function automatic logic [7:0] fval(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Reference model: queue = bytes fval(ib_pc .. ib_pc+count-1).
    int          m_count;
    logic [15:0] m_ib_pc, m_fetch_pc;

    // Bus monitor / memory responder state.
    bit          tr_act, tr_dat, tr_drop, acked_last;
    int          tr_age, tr_lat;
    logic [15:0] tr_addr;
    int          lat_cfg  = 1;
    bit          lat_rand = 0;
    logic [15:0] pf_log[$];
    bit          kind_log[$];

    // Execute-stage requester state.
    bit          dp, exp_done;
    int          dp_wait, done_cnt;
    logic [7:0]  dp_rval;

    task automatic model_reset();
        m_count    = 0;
        m_ib_pc    = RST_PC;
        m_fetch_pc = RST_PC;
        tr_act     = 0;
        acked_last = 0;
        exp_done   = 0;
        dp         = 0;
    endtask

    task automatic idle_inputs();
        ib_consume = 0;
        ib_len     = 0;
        redirect   = 0;
    endtask

    // One clock: called and returning at a falling edge.
    task automatic step();
        int lim;
        bit push, pop_ok;
        if (rst_n) begin
            lim = (m_count > 3) ? 3 : m_count;
            chk("ib_pc", ib_pc, m_ib_pc);
            chk("ib_avail", ib_avail, lim);
            if (lim > 0) chk("ib_byte0", ib_byte0, fval(m_ib_pc));
            if (lim > 1) chk("ib_byte1", ib_byte1, fval(m_ib_pc + 16'd1));
            if (lim > 2) chk("ib_byte2", ib_byte2, fval(m_ib_pc + 16'd2));
            chk("dat_done", dat_done, exp_done);
            if (exp_done) begin
                if (!dat_we) chk("dat_rdata", dat_rdata, dp_rval);
                done_cnt++;
                dp       = 0;
                dat_req  = 0;
                exp_done = 0;
            end
            if (acked_last) chk("req_gap", mem_req, 0);
            if (tr_act) begin
                chk("req_hold", mem_req, 1);
                chk("addr_hold", mem_addr, tr_addr);
            end else if (mem_req) begin
                tr_act  = 1;
                tr_age  = 0;
                tr_drop = 0;
                tr_addr = mem_addr;
                tr_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
                tr_dat  = dp && (mem_addr == dat_addr);
                kind_log.push_back(tr_dat);
                pf_log.push_back(mem_addr);
                if (tr_dat) begin
                    chk("dat_we_bus", mem_we, dat_we);
                    if (dat_we) chk("dat_wdata_bus", mem_wdata, dat_wdata);
                end else begin
                    chk("pf_addr", mem_addr, m_fetch_pc);
                    chk("pf_we", mem_we, 0);
                    chk("pf_room", m_count < QD, 1);
                end
            end
            if (dp) begin
                dp_wait++;
                if (dp_wait > 16) begin
                    chk("dat_latency", dp_wait, 16);
                    dp      = 0;
                    dat_req = 0;
                end
            end
        end
        mem_ack   = tr_act && (tr_age == tr_lat);
        mem_rdata = (tr_act && tr_dat) ? dp_rval : fval(tr_addr);
        if (tr_act && !tr_dat && redirect) tr_drop = 1;
        push   = mem_ack && !tr_dat && !tr_drop;
        pop_ok = ib_consume && (ib_len != 0) && (ib_len <= m_count);
        if (rst_n) begin
            if (redirect) begin
                m_count    = 0;
                m_ib_pc    = redirect_pc;
                m_fetch_pc = redirect_pc;
            end else begin
                if (push) begin
                    m_count++;
                    m_fetch_pc++;
                end
                if (pop_ok) begin
                    m_count -= ib_len;
                    m_ib_pc += 16'(ib_len);
                end
            end
            if (mem_ack && tr_dat) exp_done = 1;
        end
        acked_last = mem_ack;
        @(posedge clk);
        if (mem_ack) tr_act = 0;
        else if (tr_act) tr_age++;
        @(negedge clk);
    endtask

    task automatic start_dat(input bit we, input logic [15:0] a,
                             input logic [7:0] wd, input logic [7:0] rv);
        dat_req   = 1;
        dat_we    = we;
        dat_addr  = a;
        dat_wdata = wd;
        dp_rval   = rv;
        dp        = 1;
        dp_wait   = 0;
    endtask

    task automatic wait_dat();
        int n = 0;
        while (dp && n < 40) begin
            step();
            n++;
        end
        chk("dat_complete", dp, 0);
    endtask

    task automatic wait_pf_start();
        int n = 0;
        while (!(mem_req && !tr_act && !mem_we) && n < 60) begin
            step();
            n++;
        end
        chk("pf_start_seen", mem_req && !tr_act, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int consumed, n, dc;
        rst_n = 0;
        mem_ack = 0;
        mem_rdata = 0;
        dat_req = 0;
        dat_we = 0;
        dat_addr = 0;
        dat_wdata = 0;
        redirect_pc = 0;
        done_cnt = 0;
        idle_inputs();
        model_reset();

        // 1: reset values, then fill from RESET_PC
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_dat_done", dat_done, 0);
        chk("rst_dat_rdata", dat_rdata, 0);
        chk("rst_ib_avail", ib_avail, 0);
        chk("rst_ib_pc", ib_pc, RST_PC);
        rst_n = 1;
        repeat (60) step();
        chk("t1_npf", pf_log.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < pf_log.size()) chk("t1_addr", pf_log[i], i);
        chk("t1_req_idle", mem_req, 0);
        chk("t1_avail", ib_avail, 3);
        chk("t1_b0", ib_byte0, 8'h00);
        chk("t1_b1", ib_byte1, 8'h01);
        chk("t1_b2", ib_byte2, 8'h02);
        chk("t1_pc", ib_pc, 16'h0000);

        // 2: consume 2 from full, refill resumes at 0010
        pf_log.delete();
        ib_consume = 1;
        ib_len = 2;
        step();
        idle_inputs();
        chk("t2_pc", ib_pc, 16'h0002);
        chk("t2_b0", ib_byte0, 8'h02);
        repeat (20) step();
        chk("t2_npf", pf_log.size(), 2);
        if (pf_log.size() > 1) begin
            chk("t2_addr0", pf_log[0], 16'h0010);
            chk("t2_addr1", pf_log[1], 16'h0011);
        end

        // 3: data write takes priority, then data read
        pf_log.delete();
        kind_log.delete();
        dc = done_cnt;
        ib_consume = 1;
        ib_len = 3;
        start_dat(1, 16'h0200, 8'h5A, 8'h00);
        step();
        idle_inputs();
        wait_dat();
        chk("t3_first_is_data", kind_log.size() > 0 && kind_log[0], 1);
        if (pf_log.size() > 0) chk("t3_waddr", pf_log[0], 16'h0200);
        start_dat(0, 16'h0300, 8'h00, 8'hA5);
        wait_dat();
        chk("t3_rdata", dat_rdata, 8'hA5);
        repeat (4) step();
        chk("t3_done_pulses", done_cnt - dc, 2);

        // 4: redirect during prefetch, then coincident with ack
        lat_cfg = 2;
        ib_consume = 1;
        ib_len = 1;
        step();
        idle_inputs();
        wait_pf_start();
        redirect = 1;
        redirect_pc = 16'hC000;
        step();
        redirect = 0;
        step();
        step();
        chk("t4a_avail", ib_avail, 0);
        chk("t4a_pc", ib_pc, 16'hC000);
        wait_pf_start();
        chk("t4a_next", mem_addr, 16'hC000);
        step();
        step();
        redirect = 1;
        step();
        redirect = 0;
        chk("t4b_avail", ib_avail, 0);
        chk("t4b_pc", ib_pc, 16'hC000);
        wait_pf_start();
        chk("t4b_next", mem_addr, 16'hC000);

        // 5: wrap through FFFF with back-to-back 1-byte consumes
        lat_cfg = 1;
        redirect = 1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 0;
        pf_log.delete();
        consumed = 0;
        n = 0;
        while (consumed < 40 && n < 400) begin
            ib_consume = (m_count >= 1);
            ib_len = 1;
            if (ib_consume) consumed++;
            step();
            n++;
        end
        idle_inputs();
        chk("t5_consumed", consumed, 40);
        chk("t5_pc", ib_pc, 16'h0026);
        if (pf_log.size() > 3) begin
            chk("t5_a0", pf_log[0], 16'hFFFE);
            chk("t5_a1", pf_log[1], 16'hFFFF);
            chk("t5_a2", pf_log[2], 16'h0000);
            chk("t5_a3", pf_log[3], 16'h0001);
        end else chk("t5_npf", pf_log.size(), 4);
        redirect = 1;
        redirect_pc = 16'h0100;
        step();
        redirect = 0;
        n = 0;
        while (m_count != 2 && n < 50) begin
            step();
            n++;
        end
        ib_consume = 1;
        ib_len = 3;
        step();
        chk("t5_illegal_len3", ib_pc, 16'h0100);
        ib_len = 0;
        step();
        idle_inputs();
        chk("t5_illegal_len0", ib_pc, 16'h0100);

        // random traffic
        redirect = 1;
        redirect_pc = 16'h1000;
        step();
        redirect = 0;
        lat_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            redirect = ($urandom % 40) == 0;
            redirect_pc = 16'($urandom_range(0, 16'h3FFF));
            ib_consume = ($urandom % 3) != 0;
            ib_len = 2'($urandom % 4);
            if (!dp && c > 5 && ($urandom % 12) == 0)
                start_dat(1'($urandom % 2), 16'h8000 | 16'($urandom),
                          8'($urandom), 8'($urandom));
            step();
        end
        idle_inputs();
        if (dp) wait_dat();
        lat_rand = 0;

        // 6: asynchronous reset in the middle of a data access
        lat_cfg = 3;
        start_dat(0, 16'h9000, 8'h00, 8'h3C);
        n = 0;
        while (!(tr_act && tr_dat) && n < 20) begin
            step();
            n++;
        end
        chk("t6_in_dt", tr_act && tr_dat, 1);
        dc = done_cnt;
        #2 rst_n = 0;
        #1;
        chk("t6_req_async", mem_req, 0);
        chk("t6_no_done", dat_done, 0);
        dat_req = 0;
        mem_ack = 0;
        model_reset();
        @(negedge clk);
        step();
        step();
        chk("t6_rst_done", dat_done, 0);
        rst_n = 1;
        pf_log.delete();
        repeat (12) step();
        if (pf_log.size() > 0) chk("t6_first_pf", pf_log[0], RST_PC);
        else chk("t6_npf", pf_log.size(), 1);
        chk("t6_done_cnt", done_cnt, dc);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
